// File: rtl/timer_prescaler_ctrl.sv
// Shared 10-bit prescaler and per-timer count-enable scheduler for Timer/Counter0 and Timer/Counter1.
// Optional macro TIMER_EXT_SYNC_EN adds a 2-flop synchroniser on each external clock pin.
module timer_prescaler_ctrl #(
  parameter int unsigned PRESC_WIDTH = 10
) (
  input  logic                   sysClock,
  input  logic                   rst,
  input  logic                   psr10,
  input  logic [2:0]             cs0,
  input  logic [2:0]             cs1,
  input  logic                   t0_pin,
  input  logic                   t1_pin,
  output logic                   clk_en0,
  output logic                   clk_en1,
  output logic [PRESC_WIDTH-1:0] presc_cnt
);

  localparam int unsigned NUM_TIMERS = 2;

  logic                  tap1_c;
  logic                  tap8_c;
  logic                  tap64_c;
  logic                  tap256_c;
  logic                  tap1024_c;
  logic [NUM_TIMERS-1:0] pin_sync_c;
  logic [NUM_TIMERS-1:0] pin_hist;
  logic [NUM_TIMERS-1:0] rise_c;
  logic [NUM_TIMERS-1:0] fall_c;
  logic                  en0_next_c;
  logic                  en1_next_c;

  // Free-running prescaler; psr10 restarts it from zero.
  always_ff @(posedge sysClock) begin
    if (rst || psr10) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
    end
  end

  // Divided taps; a prescaler reset in this cycle suppresses all divided taps.
  always_comb begin
    tap1_c    = 1'b1;
    tap8_c    = (presc_cnt[2:0] == 3'h7)    && !psr10;
    tap64_c   = (presc_cnt[5:0] == 6'h3f)   && !psr10;
    tap256_c  = (presc_cnt[7:0] == 8'hff)   && !psr10;
    tap1024_c = (presc_cnt[9:0] == 10'h3ff) && !psr10;
  end

`ifdef TIMER_EXT_SYNC_EN
  logic [NUM_TIMERS-1:0] pin_s1;
  logic [NUM_TIMERS-1:0] pin_s2;

  always_ff @(posedge sysClock) begin
    if (rst) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
    end else begin
      pin_s1 <= {t1_pin, t0_pin};
      pin_s2 <= pin_s1;
    end
  end

  assign pin_sync_c = pin_s2;
`else
  assign pin_sync_c = {t1_pin, t0_pin};
`endif

  // Edge history runs regardless of clock select so a new select never sees a stale edge.
  always_ff @(posedge sysClock) begin
    if (rst) begin
      pin_hist <= '0;
    end else begin
      pin_hist <= pin_sync_c;
    end
  end

  assign rise_c = pin_sync_c & ~pin_hist;
  assign fall_c = ~pin_sync_c & pin_hist;

  function automatic logic sel_en(
    input logic [2:0] cs,
    input logic       t1,
    input logic       t8,
    input logic       t64,
    input logic       t256,
    input logic       t1024,
    input logic       rise,
    input logic       fall
  );
    logic en;
    en = 1'b0;
    case (cs)
      3'b001:  en = t1;
      3'b010:  en = t8;
      3'b011:  en = t64;
      3'b100:  en = t256;
      3'b101:  en = t1024;
      3'b110:  en = fall;
      3'b111:  en = rise;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  always_comb begin
    en0_next_c = sel_en(cs0, tap1_c, tap8_c, tap64_c, tap256_c, tap1024_c, rise_c[0], fall_c[0]);
    en1_next_c = sel_en(cs1, tap1_c, tap8_c, tap64_c, tap256_c, tap1024_c, rise_c[1], fall_c[1]);
  end

  always_ff @(posedge sysClock) begin
    if (rst) begin
      clk_en0 <= 1'b0;
      clk_en1 <= 1'b0;
    end else begin
      clk_en0 <= en0_next_c;
      clk_en1 <= en1_next_c;
    end
  end

endmodule
